// File: rtl/floppy_step_ctrl.sv
// Floppy head-positioning sequencer: accepts seek-home and relative step commands
// and drives timed active-low STEP/DIR pulses while tracking the head position.
module floppy_step_ctrl #(
  parameter int DIR_SETUP_CYC   = 51,
  parameter int PULSE_CYC       = 151,
  parameter int STEP_PERIOD_CYC = 150750,
  parameter int SETTLE_CYC      = 753750,
  parameter int MAX_TRACK       = 79,
  parameter int HOME_LIMIT      = 90,
  parameter int CNT_W           = 20
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_home,
  input  logic       cmd_dir,
  input  logic [7:0] cmd_count,
  input  logic       track0_n,
  output logic       step_n,
  output logic       dir_n,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] track,
  output logic       track_valid
);

  typedef enum logic [2:0] {S_IDLE, S_DIR_SETUP, S_PULSE, S_GAP, S_SETTLE, S_DONE} state_t;

  localparam logic [CNT_W-1:0] DIR_LOAD    = CNT_W'(DIR_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(STEP_PERIOD_CYC - PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [7:0]       MAX_TRK     = 8'(MAX_TRACK);
  localparam logic [7:0]       HOME_LIM    = 8'(HOME_LIMIT);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       steps_left_reg, steps_left_next;
  logic [7:0]       step_cnt_reg, step_cnt_next;
  logic [7:0]       track_reg, track_next;
  logic             track_valid_reg, track_valid_next;
  logic             home_reg, home_next;
  logic             dir_in_reg, dir_in_next;
  logic             dir_n_reg, dir_n_next;
  logic             error_reg, error_next;
  logic             alive_reg;
  logic [1:0]       t0_sync_reg;

  logic       t0;
  logic       accept;
  logic       phase_end;
  logic [7:0] room;
  logic [7:0] eff_count;

  // TRACK0 is asynchronous to our clock; idle (high) value keeps t0 deasserted out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      t0_sync_reg <= 2'b11;
      alive_reg   <= 1'b0;
    end else begin
      t0_sync_reg <= {t0_sync_reg[0], track0_n};
      alive_reg   <= 1'b1;
    end
  end

  assign t0        = ~t0_sync_reg[1];
  assign cmd_ready = alive_reg & locked & (state_reg == S_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign phase_end = (cnt_reg == '0);
  assign room      = cmd_dir ? (MAX_TRK - track_reg) : track_reg;
  assign eff_count = (cmd_count < room) ? cmd_count : room;

  always_comb begin
    state_next       = state_reg;
    cnt_next         = phase_end ? cnt_reg : cnt_reg - 1'b1;
    steps_left_next  = steps_left_reg;
    step_cnt_next    = step_cnt_reg;
    track_next       = track_reg;
    track_valid_next = track_valid_reg;
    home_next        = home_reg;
    dir_in_next      = dir_in_reg;
    dir_n_next       = dir_n_reg;
    error_next       = error_reg;

    if (!locked && state_reg != S_IDLE) begin
      state_next       = S_IDLE;
      track_valid_next = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            error_next    = 1'b0;
            home_next     = cmd_home;
            dir_in_next   = cmd_dir;
            step_cnt_next = 8'd0;
            if (cmd_home) begin
              dir_n_next = 1'b1;
              cnt_next   = DIR_LOAD;
              state_next = S_DIR_SETUP;
            end else if (!track_valid_reg) begin
              error_next = 1'b1;
              state_next = S_DONE;
            end else if (eff_count == 8'd0) begin
              state_next = S_DONE;
            end else begin
              steps_left_next = eff_count;
              dir_n_next      = ~cmd_dir;
              cnt_next        = DIR_LOAD;
              state_next      = S_DIR_SETUP;
            end
          end
        end
        // Both phases end in the same decision: home sense, home give-up, or next step.
        S_DIR_SETUP, S_GAP: begin
          if (phase_end) begin
            if (home_reg && t0) begin
              track_next       = 8'd0;
              track_valid_next = 1'b1;
              cnt_next         = SETTLE_LOAD;
              state_next       = (step_cnt_reg != 8'd0) ? S_SETTLE : S_DONE;
            end else if (home_reg && step_cnt_reg == HOME_LIM) begin
              track_valid_next = 1'b0;
              error_next       = 1'b1;
              cnt_next         = SETTLE_LOAD;
              state_next       = S_SETTLE;
            end else if (home_reg || steps_left_reg != 8'd0) begin
              cnt_next   = PULSE_LOAD;
              state_next = S_PULSE;
            end else begin
              cnt_next   = SETTLE_LOAD;
              state_next = S_SETTLE;
            end
          end
        end
        S_PULSE: begin
          if (phase_end) begin
            step_cnt_next = step_cnt_reg + 8'd1;
            if (!home_reg) begin
              steps_left_next = steps_left_reg - 8'd1;
              track_next      = dir_in_reg ? track_reg + 8'd1 : track_reg - 8'd1;
            end
            cnt_next   = GAP_LOAD;
            state_next = S_GAP;
          end
        end
        S_SETTLE: begin
          if (phase_end) state_next = S_DONE;
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= S_IDLE;
      cnt_reg         <= '0;
      steps_left_reg  <= 8'd0;
      step_cnt_reg    <= 8'd0;
      track_reg       <= 8'd0;
      track_valid_reg <= 1'b0;
      home_reg        <= 1'b0;
      dir_in_reg      <= 1'b0;
      dir_n_reg       <= 1'b1;
      error_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      steps_left_reg  <= steps_left_next;
      step_cnt_reg    <= step_cnt_next;
      track_reg       <= track_next;
      track_valid_reg <= track_valid_next;
      home_reg        <= home_next;
      dir_in_reg      <= dir_in_next;
      dir_n_reg       <= dir_n_next;
      error_reg       <= error_next;
    end
  end

  assign step_n      = (state_reg != S_PULSE);
  assign dir_n       = dir_n_reg;
  assign busy        = (state_reg != S_IDLE);
  assign done        = (state_reg == S_DONE);
  assign error       = error_reg;
  assign track       = track_reg;
  assign track_valid = track_valid_reg;

endmodule
